mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS32 pipeline, between EX and WB.
- Owns a word-organised data memory and performs lw/lh/lhu/lb/lbu/sw/sh/sb with a configurable access latency.
- Stalls upstream while an access is pending.
- Registers the ALU result, load result and instruction metadata into the MEM/WB pipeline register consumed by wb_stage.

Parameters:
DEPTH, 256, data memory size in 32-bit words (power of two)
WAIT_CYCLES, 0, extra cycles per load/store (0 = single-cycle access)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  EX/MEM register holds a real instruction
opcode  input  6  instruction opcode from EX
instr_type  input  2  00 R-type, 11 I-type, others ignored downstream
rd_add  input  5  R-type destination
rt_add  input  5  I-type destination / store source index
alu_result  input  32  ALU result; effective address for memory ops
store_data  input  32  rt value for stores
stall  output  1  upstream must hold all inputs this cycle
opcode_out  output  6  registered opcode to WB
instr_type_out  output  2  registered type to WB
rd_add_out  output  5  registered rd
rt_add_out  output  5  registered rt
write_data  output  32  registered alu_result
write_material  output  32  registered load result (0 for non-loads)
misalign  output  1  one-cycle pulse, completed access was misaligned

Behaviour:
- Reset values:
  - all outputs 0, except instr_type_out = 2'b01, so WB performs no write.
  - FSM to IDLE, wait counter 0.
  - Memory contents are not reset.
- Memory ops: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100, sw 101011, sh 101001, sb 101000; only when instr_type = 11. All other opcodes/types are pass-through.
- Addressing: word index = alu_result[log2(DEPTH)+1:2]; upper bits ignored (wraps modulo DEPTH).
- Byte lanes: little-endian, byte 0 = bits 7:0.
  - Halfword at addr[1] selects bits 31:16.
- Load extension:
  - lb/lh sign-extend to 32 bits.
  - lbu/lhu zero-extend.
- Stores:
  - sb/sh write only the addressed lane(s); other bytes are preserved.
  - sw writes the full word.
- Misalignment (word with addr[1:0]≠0, half with addr[0]=1):
  - store suppressed (memory unchanged); load returns write_material = 0.
  - misalign = 1 for the completion cycle only.
  - Instruction still retires normally to WB.
- FSM:
  - IDLE: the cycle in which a pass-through op or bubble completes, or a memory op completes when WAIT_CYCLES = 0.
  - IDLE with in_valid & mem op & WAIT_CYCLES > 0: cnt <= WAIT_CYCLES−1, go to ACCESS, stall = 1.
  - ACCESS with cnt ≠ 0: cnt decrements, stall = 1.
  - ACCESS with cnt = 0: stall = 0, completion; go to IDLE.
- stall is combinational: (IDLE & in_valid & mem op & WAIT_CYCLES>0) | (ACCESS & cnt≠0). No stall for pass-through ops or bubbles.
- Completion edge:
  - store commits to memory.
  - load data is read from current memory contents and registered.
  - all *_out, write_data and write_material update.
- Latency:
  - pass-through: 1 cycle.
  - memory op: 1+WAIT_CYCLES cycles from first presentation to outputs.
- Bubble (in_valid = 0 in IDLE): instr_type_out <= 01, write_material <= 0, misalign <= 0; other outputs hold.
- While stall = 1: outputs hold their previous values; inputs are sampled again at completion (upstream holds them).
- Back-to-back: a store followed by a load to the same word sees the stored data, because the store commits at its completion edge before the load's read.
- rst mid-ACCESS: access abandoned, no memory write, outputs to reset values, FSM to IDLE.

Test Plan:
- Reset held 2 cycles → instr_type_out = 01, stall = 0, all data outputs 0.
- WAIT_CYCLES=0: R-type rd=5, alu_result=0x0000_00AA → next cycle instr_type_out=00, rd_add_out=5, write_data=0xAA, write_material=0.
- sw 0xDEADBEEF @0x10, then lb @0x13 → write_material=0xFFFFFFDE; lbu @0x13 → 0x000000DE; lh @0x12 → 0xFFFFDEAD; lhu @0x10 → 0x0000BEEF.
- sb 0x11 @0x11 over 0xDEADBEEF → lw @0x10 returns 0xDEAD11EF.
- lw @0x12 (misaligned) → misalign pulse 1 cycle, write_material=0; sh @0x13 → memory word unchanged.
- WAIT_CYCLES=2: lw issued → stall high exactly 2 cycles, outputs update on 3rd edge; rst asserted during 2nd stall cycle on an sw → memory unchanged, FSM IDLE, stall=0.

Source files
------------

// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/MEM handshake bundle feeding the memory-access stage.
//   in_valid    EX/MEM register holds a real instruction
//   opcode      instruction opcode
//   instr_type  00 R-type, 11 I-type, others ignored downstream
//   rd_add      R-type destination
//   rt_add      I-type destination / store source index
//   alu_result  ALU result; effective address for memory ops
//   store_data  rt value for stores
//   stall       upstream must hold every field above this cycle
// master = EX side (drives the instruction), slave = mem_stage.
interface mem_stage_if;
   logic        in_valid;
   logic [5:0]  opcode;
   logic [1:0]  instr_type;
   logic [4:0]  rd_add;
   logic [4:0]  rt_add;
   logic [31:0] alu_result;
   logic [31:0] store_data;
   logic        stall;

   modport master (
      output in_valid, opcode, instr_type, rd_add, rt_add, alu_result, store_data,
      input  stall
   );

   modport slave (
      input  in_valid, opcode, instr_type, rd_add, rt_add, alu_result, store_data,
      output stall
   );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MIPS32 MEM stage. Owns a word-organised little-endian data
// memory, executes lw/lh/lhu/lb/lbu/sw/sh/sb with WAIT_CYCLES extra cycles
// per access, stalls EX while an access is pending and registers the
// MEM/WB pipeline register.
//   clk, rst        clock / synchronous active-high reset
//   ex              EX/MEM handshake (mem_stage_if.slave), stall driven here
//   opcode_out      registered opcode
//   instr_type_out  registered type (01 = no writeback, bubble/reset)
//   rd_add_out      registered rd
//   rt_add_out      registered rt
//   write_data      registered alu_result
//   write_material  registered load result (0 for non-loads / misaligned)
//   misalign        one-cycle pulse: the completed access was misaligned
module mem_stage #(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst,
   mem_stage_if.slave        ex,
   output logic [5:0]        opcode_out,
   output logic [1:0]        instr_type_out,
   output logic [4:0]        rd_add_out,
   output logic [4:0]        rt_add_out,
   output logic [31:0]       write_data,
   output logic [31:0]       write_material,
   output logic              misalign
);

   localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam bit          HAS_WAIT = (WAIT_CYCLES > 0);
   localparam logic [CW-1:0] CNT_INIT = HAS_WAIT ? CW'(WAIT_CYCLES - 1) : '0;

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [31:0]    mem [DEPTH];

   logic           is_load, is_store, is_mem;
   logic           acc_w, acc_h, sgn, mis;
   logic [AW-1:0]  widx;
   logic [31:0]    rd_word, ld_val, st_word;
   logic [7:0]     sel_b;
   logic [15:0]    sel_h;
   logic           stall_i, complete, retire;

   assign widx    = ex.alu_result[AW+1:2];
   assign rd_word = mem[widx];

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      acc_w    = 1'b0;
      acc_h    = 1'b0;
      sgn      = 1'b0;
      if (ex.instr_type == 2'b11) begin
         case (ex.opcode)
            6'b100011: begin is_load  = 1'b1; acc_w = 1'b1; end
            6'b100001: begin is_load  = 1'b1; acc_h = 1'b1; sgn = 1'b1; end
            6'b100101: begin is_load  = 1'b1; acc_h = 1'b1; end
            6'b100000: begin is_load  = 1'b1; sgn   = 1'b1; end
            6'b100100: begin is_load  = 1'b1; end
            6'b101011: begin is_store = 1'b1; acc_w = 1'b1; end
            6'b101001: begin is_store = 1'b1; acc_h = 1'b1; end
            6'b101000: begin is_store = 1'b1; end
            default:   ;
         endcase
      end
      is_mem = is_load | is_store;
      mis    = (acc_w && (ex.alu_result[1:0] != 2'b00)) || (acc_h && ex.alu_result[0]);

      case (ex.alu_result[1:0])
         2'd0:    sel_b = rd_word[7:0];
         2'd1:    sel_b = rd_word[15:8];
         2'd2:    sel_b = rd_word[23:16];
         default: sel_b = rd_word[31:24];
      endcase
      sel_h = ex.alu_result[1] ? rd_word[31:16] : rd_word[15:0];

      ld_val = '0;
      if (is_load && !mis) begin
         if (acc_w)      ld_val = rd_word;
         else if (acc_h) ld_val = sgn ? {{16{sel_h[15]}}, sel_h} : {16'h0000, sel_h};
         else            ld_val = sgn ? {{24{sel_b[7]}}, sel_b} : {24'h000000, sel_b};
      end

      // Read-modify-write merge: untouched lanes keep their current bytes.
      st_word = rd_word;
      if (acc_w) begin
         st_word = ex.store_data;
      end else if (acc_h) begin
         if (ex.alu_result[1]) st_word[31:16] = ex.store_data[15:0];
         else                  st_word[15:0]  = ex.store_data[15:0];
      end else begin
         case (ex.alu_result[1:0])
            2'd0:    st_word[7:0]   = ex.store_data[7:0];
            2'd1:    st_word[15:8]  = ex.store_data[7:0];
            2'd2:    st_word[23:16] = ex.store_data[7:0];
            default: st_word[31:24] = ex.store_data[7:0];
         endcase
      end
   end

   assign stall_i  = ((state == IDLE) && ex.in_valid && is_mem && HAS_WAIT) ||
                     ((state == ACCESS) && (cnt != '0));
   assign complete = ((state == IDLE) && !stall_i) || ((state == ACCESS) && (cnt == '0));
   // An ACCESS completion always retires the instruction held upstream.
   assign retire   = complete && ((state == ACCESS) || ex.in_valid);
   assign ex.stall = stall_i;

   always_ff @(posedge clk) begin
      if (!rst && retire && is_store && !mis) begin
         mem[widx] <= st_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         cnt            <= '0;
         opcode_out     <= '0;
         instr_type_out <= 2'b01;
         rd_add_out     <= '0;
         rt_add_out     <= '0;
         write_data     <= '0;
         write_material <= '0;
         misalign       <= 1'b0;
      end else begin
         misalign <= 1'b0;
         case (state)
            IDLE: begin
               if (stall_i) begin
                  state <= ACCESS;
                  cnt   <= CNT_INIT;
               end
            end
            ACCESS: begin
               if (cnt != '0) cnt <= cnt - 1'b1;
               else           state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (retire) begin
            opcode_out     <= ex.opcode;
            instr_type_out <= ex.instr_type;
            rd_add_out     <= ex.rd_add;
            rt_add_out     <= ex.rt_add;
            write_data     <= ex.alu_result;
            write_material <= ld_val;
            misalign       <= is_mem && mis;
         end else if ((state == IDLE) && !ex.in_valid) begin
            instr_type_out <= 2'b01;
            write_material <= '0;
         end
      end
   end

endmodule
